// File: rtl/sr_latch_ctrl_if.sv
// Requester-side bundle for the SR latch controller:
// request/grant handshake plus completion status.
interface sr_latch_ctrl_if #(
    parameter int NREQ = 4
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0] req;
    logic [NREQ-1:0] op;
    logic [NREQ-1:0] gnt;
    logic            busy;
    logic            done;
    logic            err;
    logic [IW-1:0]   resp_id;

    modport master (
        output req, op,
        input  gnt, busy, done, err, resp_id
    );

    modport slave (
        input  req, op,
        output gnt, busy, done, err, resp_id
    );
endinterface

// File: rtl/sr_latch_ctrl.sv
// Round-robin shared controller for an external NAND SR latch:
// pulses active-low s/r, waits a guard time, checks feedback.
module sr_latch_ctrl #(
    parameter int NREQ    = 4,
    parameter int PULSE_W = 2,
    parameter int GUARD_W = 3
) (
    input  logic clk,
    input  logic rst_n,
    sr_latch_ctrl_if.slave bus,
    output logic s,
    output logic r,
    input  logic q,
    input  logic qbar
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, DRIVE, GUARD, CHECK} state_t;

    state_t          state, state_nx;
    logic [3:0]      cnt, cnt_nx;
    logic [IW-1:0]   ptr, ptr_nx;
    logic [IW-1:0]   id, id_nx;
    logic [IW-1:0]   win;
    logic            hit;
    logic            op_l, op_nx;
    logic [NREQ-1:0] gnt_q, gnt_nx;
    logic            s_nx, r_nx;
    logic [1:0]      q_sync, qb_sync;
    logic            qs, qbs;
    int              idx;

    assign qs  = q_sync[1];
    assign qbs = qb_sync[1];

    // Two-flop synchronizers for the asynchronous latch feedback
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_sync  <= 2'b00;
            qb_sync <= 2'b00;
        end else begin
            q_sync  <= {q_sync[0], q};
            qb_sync <= {qb_sync[0], qbar};
        end
    end

    // Round-robin pick: first active request at or after ptr
    always_comb begin
        hit = 1'b0;
        win = '0;
        idx = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!hit && bus.req[idx]) begin
                hit = 1'b1;
                win = IW'(idx);
            end
        end
    end

    // Next state; s/r are derived from the next state so they are
    // registered and can never glitch low together
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        ptr_nx   = ptr;
        id_nx    = id;
        op_nx    = op_l;
        gnt_nx   = '0;
        unique case (state)
            IDLE: begin
                if (hit) begin
                    state_nx    = DRIVE;
                    cnt_nx      = 4'(PULSE_W - 1);
                    gnt_nx[win] = 1'b1;
                    id_nx       = win;
                    op_nx       = bus.op[win];
                    ptr_nx      = (win == IW'(NREQ - 1)) ? '0 : win + 1'b1;
                end
            end
            DRIVE: begin
                if (cnt == 4'd0) begin
                    state_nx = GUARD;
                    cnt_nx   = 4'(GUARD_W - 1);
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            GUARD: begin
                if (cnt == 4'd0) state_nx = CHECK;
                else             cnt_nx   = cnt - 4'd1;
            end
            CHECK:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        s_nx = !(state_nx == DRIVE && op_nx);
        r_nx = !(state_nx == DRIVE && !op_nx);
    end

    // State, grant pulse and latch drive registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 4'd0;
            ptr   <= '0;
            id    <= '0;
            op_l  <= 1'b0;
            gnt_q <= '0;
            s     <= 1'b1;
            r     <= 1'b1;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            ptr   <= ptr_nx;
            id    <= id_nx;
            op_l  <= op_nx;
            gnt_q <= gnt_nx;
            s     <= s_nx;
            r     <= r_nx;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.busy    = (state != IDLE);
    assign bus.resp_id = id;
    assign bus.done    = (state == CHECK) && (qs == op_l) && (qbs == !qs);
    assign bus.err     = (state == CHECK) && !((qs == op_l) && (qbs == !qs));
endmodule
